// File: rtl/cnn_l1_seq_if.sv
// Bundles the kernel-byte stream, the pixel stream, the cnn_l1 datapath hookup and the result stream.
// slave = the sequencer; master = the DMA / cnn_l1 / result consumer side.
interface cnn_l1_seq_if;
   logic         wt_valid;
   logic [7:0]   wt_data;
   logic         wt_ready;
   logic         pix_valid;
   logic [23:0]  pix_data;
   logic         pix_ready;
   logic         conv_clr;
   logic [7:0]   conv_pxl_0;
   logic [7:0]   conv_pxl_1;
   logic [7:0]   conv_pxl_2;
   logic [215:0] conv_kernel;
   logic         conv_valid;
   logic [15:0]  conv_sum;
   logic         out_valid;
   logic [15:0]  out_data;

   modport master (
      output wt_valid, wt_data, pix_valid, pix_data, conv_valid, conv_sum,
      input  wt_ready, pix_ready, conv_clr, conv_pxl_0, conv_pxl_1, conv_pxl_2,
      input  conv_kernel, out_valid, out_data
   );

   modport slave (
      input  wt_valid, wt_data, pix_valid, pix_data, conv_valid, conv_sum,
      output wt_ready, pix_ready, conv_clr, conv_pxl_0, conv_pxl_1, conv_pxl_2,
      output conv_kernel, out_valid, out_data
   );
endinterface

// File: rtl/cnn_l1_seq.sv
// Frame sequencer for the 3-channel layer-1 conv datapath: kernel load, clear, pixel stream, result drain.
// Optional build macro CNN_L1_SEQ_RELU_EN clamps negative results to zero on out_data.
module cnn_l1_seq #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int DRAIN_TO = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic reload,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic err,
   cnn_l1_seq_if.slave sif
);
   localparam int PIX_N = IMG_W * IMG_H;
   localparam int RES_N = (IMG_W - 2) * (IMG_H - 2);
   localparam int PW    = $clog2(PIX_N + 1);
   localparam int RW    = $clog2(RES_N + 1);
   localparam int DW    = $clog2(DRAIN_TO + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_WT, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t          state_reg, state_next;
   logic [4:0]      wt_idx_reg, wt_idx_next;
   logic [PW-1:0]   pix_cnt_reg, pix_cnt_next;
   logic [RW-1:0]   res_cnt_reg, res_cnt_next;
   logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
   logic            err_reg, err_next;
   logic            loaded_reg, loaded_next;
   logic [7:0]      pxl0_reg, pxl1_reg, pxl2_reg;
   logic            out_valid_reg;
   logic [15:0]     out_data_reg;
   logic            wt_we, pix_acc, res_fwd, count_en;
   logic            wt_ready, pix_ready, conv_clr;
   wire  [215:0]    kernel_vec;

   always_comb begin
      state_next     = state_reg;
      wt_idx_next    = wt_idx_reg;
      pix_cnt_next   = pix_cnt_reg;
      res_cnt_next   = res_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      err_next       = err_reg;
      loaded_next    = loaded_reg;
      wt_ready       = 1'b0;
      pix_ready      = 1'b0;
      conv_clr       = 1'b1;
      busy           = 1'b1;
      done           = 1'b0;
      wt_we          = 1'b0;
      pix_acc        = 1'b0;
      count_en       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               err_next    = 1'b0;
               wt_idx_next = '0;
               state_next  = (reload || !loaded_reg) ? S_LOAD_WT : S_CLEAR;
            end
         end
         S_LOAD_WT: begin
            wt_ready = 1'b1;
            if (sif.wt_valid) begin
               wt_we       = 1'b1;
               wt_idx_next = wt_idx_reg + 5'd1;
               if (wt_idx_reg == 5'd26) begin
                  loaded_next = 1'b1;
                  state_next  = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            pix_cnt_next   = '0;
            res_cnt_next   = '0;
            drain_cnt_next = '0;
            state_next     = S_STREAM;
         end
         S_STREAM: begin
            conv_clr  = 1'b0;
            pix_ready = 1'b1;
            count_en  = 1'b1;
            if (sif.pix_valid) begin
               pix_acc      = 1'b1;
               pix_cnt_next = pix_cnt_reg + 1'b1;
               if (pix_cnt_reg == PW'(PIX_N - 1)) state_next = S_DRAIN;
            end else if (pix_cnt_reg != '0) begin
               // cnn_l1 cannot stall, so a gap mid-frame corrupts the window
               err_next   = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DRAIN: begin
            conv_clr       = 1'b0;
            count_en       = 1'b1;
            drain_cnt_next = drain_cnt_reg + 1'b1;
            if (res_cnt_reg == RW'(RES_N) ||
                (sif.conv_valid && res_cnt_reg == RW'(RES_N - 1))) begin
               state_next = S_DONE;
            end else if (drain_cnt_reg == DW'(DRAIN_TO - 1)) begin
               err_next   = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      res_fwd = count_en && sif.conv_valid && (res_cnt_reg < RW'(RES_N));
      if (res_fwd) res_cnt_next = res_cnt_reg + 1'b1;

      // abort beats start and completion; err is left as it was
      if (abort) begin
         state_next = S_IDLE;
         err_next   = err_reg;
         res_fwd    = 1'b0;
         if (state_reg == S_LOAD_WT) loaded_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         wt_idx_reg    <= '0;
         pix_cnt_reg   <= '0;
         res_cnt_reg   <= '0;
         drain_cnt_reg <= '0;
         err_reg       <= 1'b0;
         loaded_reg    <= 1'b0;
         pxl0_reg      <= '0;
         pxl1_reg      <= '0;
         pxl2_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         wt_idx_reg    <= wt_idx_next;
         pix_cnt_reg   <= pix_cnt_next;
         res_cnt_reg   <= res_cnt_next;
         drain_cnt_reg <= drain_cnt_next;
         err_reg       <= err_next;
         loaded_reg    <= loaded_next;
         out_valid_reg <= res_fwd;
         if (pix_acc) begin
            pxl0_reg <= sif.pix_data[7:0];
            pxl1_reg <= sif.pix_data[15:8];
            pxl2_reg <= sif.pix_data[23:16];
         end
`ifdef CNN_L1_SEQ_RELU_EN
         out_data_reg <= sif.conv_sum[15] ? 16'h0000 : sif.conv_sum;
`else
         out_data_reg <= sif.conv_sum;
`endif
      end
   end

   // one held register per kernel byte, addressed by the load index
   generate
      for (genvar gi = 0; gi < 27; gi++) begin : g_kern
         logic [7:0] byte_reg;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)                                  byte_reg <= '0;
            else if (wt_we && wt_idx_reg == 5'(gi))      byte_reg <= sif.wt_data;
         end
         assign kernel_vec[8*gi +: 8] = byte_reg;
      end
   endgenerate

   assign err             = err_reg;
   assign sif.wt_ready    = wt_ready;
   assign sif.pix_ready   = pix_ready;
   assign sif.conv_clr    = conv_clr;
   assign sif.conv_pxl_0  = pxl0_reg;
   assign sif.conv_pxl_1  = pxl1_reg;
   assign sif.conv_pxl_2  = pxl2_reg;
   assign sif.conv_kernel = kernel_vec;
   assign sif.out_valid   = out_valid_reg;
   assign sif.out_data    = out_data_reg;
endmodule
